// File: rtl/weight_load_issuer_pkg.sv
// Shared weight-load definitions: FSM encoding, block word counts and the bit layout
// of the encoded weight-buffer write address.
package weight_load_issuer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2
    } issuer_state_t;

    localparam int KERNEL_OFFSETS = 9;
    localparam int WORDS_1X1      = 16;
    localparam int WORDS_3X3      = 144;

    localparam int WADDR_IS1X1_BIT   = 31;
    localparam int WADDR_OUT_CH_MSB  = 30;
    localparam int WADDR_OUT_CH_LSB  = 23;
    localparam int WADDR_OFFSET_MSB  = 9;
    localparam int WADDR_OFFSET_LSB  = 6;
    localparam int WADDR_IN_CH_MSB   = 3;
    localparam int WADDR_IN_CH_LSB   = 0;

endpackage

// File: rtl/weight_addr_pack.sv
// Packs kernel type, output channel, kernel offset and input channel into the
// 32-bit weight-buffer write address; every unlisted bit is zero.
module weight_addr_pack
    import weight_load_issuer_pkg::*;
(
    input  logic        is1x1,
    input  logic [7:0]  out_ch,
    input  logic [3:0]  offset,
    input  logic [3:0]  in_ch,
    output logic [31:0] waddr
);

    always_comb begin
        // NOTE: assign the whole word first so the unused fields read 0 and no latch can be inferred.
        waddr = '0;
        waddr[WADDR_IS1X1_BIT]                    = is1x1;
        waddr[WADDR_OUT_CH_MSB:WADDR_OUT_CH_LSB] = out_ch;
        waddr[WADDR_OFFSET_MSB:WADDR_OFFSET_LSB] = is1x1 ? 4'd0 : offset;
        waddr[WADDR_IN_CH_MSB:WADDR_IN_CH_LSB]   = in_ch;
    end

endmodule

// File: rtl/weight_load_issuer.sv
// Weight-load issuer: streams one kernel block (16 or 144 words) from weight SRAM into
// the weight buffer, one write per granted read, address and data cycle-aligned.
module weight_load_issuer
    import weight_load_issuer_pkg::*;
#(
    parameter int MEM_AW = 16,
    parameter int IN_CH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_is1x1,
    input  logic [7:0]        cmd_out_ch,
    input  logic [MEM_AW-1:0] cmd_src_addr,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       weight_waddr,
    output logic [31:0]       weight_wdata,
    output logic              weight_wen,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(KERNEL_OFFSETS * IN_CH);
    localparam int CH_W  = $clog2(IN_CH);

    issuer_state_t     state;
    logic              is1x1_q;
    logic [7:0]        out_ch_q;
    logic [MEM_AW-1:0] src_q;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  last_idx;
    logic [3:0]        offset;
    logic [3:0]        in_ch;
    logic [31:0]       waddr_next;
    logic [31:0]       waddr_q;
    logic              wen_q;

    // Word index runs offset-major: upper bits select the kernel offset, lower bits the input channel.
    assign offset   = 4'(idx >> CH_W);
    assign in_ch    = 4'(idx);
    assign last_idx = is1x1_q ? IDX_W'(WORDS_1X1 - 1) : IDX_W'(WORDS_3X3 - 1);

    weight_addr_pack u_pack (
        .is1x1  (is1x1_q),
        .out_ch (out_ch_q),
        .offset (offset),
        .in_ch  (in_ch),
        .waddr  (waddr_next)
    );

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            is1x1_q  <= 1'b0;
            out_ch_q <= '0;
            src_q    <= '0;
            idx      <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
        end else begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is1x1_q  <= cmd_is1x1;
                        out_ch_q <= cmd_out_ch;
                        src_q    <= cmd_src_addr;
                        idx      <= '0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_gnt) begin
                        // Capture the address with the grant; the data arrives next cycle.
                        wen_q   <= 1'b1;
                        waddr_q <= waddr_next;
                        if (idx == last_idx) begin
                            state <= LAST;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                LAST:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so the handshake reads not-ready for the whole reset interval.
    assign cmd_ready    = rst_n && (state == IDLE);
    assign mem_req      = (state == FETCH);
    assign mem_addr     = (state == FETCH) ? src_q + MEM_AW'(idx) : '0;
    assign busy         = (state == FETCH);
    assign done         = (state == LAST);
    assign weight_wen   = wen_q;
    assign weight_waddr = waddr_q;
    assign weight_wdata = wen_q ? mem_rdata : '0;

endmodule

// File: tb/tb_weight_load_issuer.sv
// Self-checking bench for weight_load_issuer: SRAM responder with selectable grant
// pattern, write monitor, and a list-based reference model of each block's writes.
module tb_weight_load_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is1x1 = 1'b0;
    logic [7:0]  cmd_out_ch = '0;
    logic [15:0] cmd_src_addr = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] weight_waddr;
    logic [31:0] weight_wdata;
    logic        weight_wen;
    logic        busy;
    logic        done;

    typedef struct { logic [31:0] waddr; logic [31:0] wdata; logic done; int cyc; } wr_t;
    typedef struct { logic [31:0] waddr; logic [31:0] wdata; logic done; } exp_t;

    wr_t         wr_q[$];
    exp_t        exp_q[$];
    int          grant_cyc[$];
    logic [15:0] grant_addr[$];
    int          accept_cyc[$];
    int          done_cyc[$];
    int          cyc, accept_cnt, done_cnt, grant_cnt;
    int          zero_viol, hold_viol, busy_viol;
    int          gnt_mode;           // 0 always, 1 toggle, 2 random
    bit          toggle_ph;
    bit          pend;
    logic [15:0] paddr;
    bit          prev_req, prev_gnt;
    logic [15:0] prev_addr;
    logic [31:0] sram [0:1023];
    int          checks, errors;

    weight_load_issuer #(.MEM_AW(16), .IN_CH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_is1x1    (cmd_is1x1),
        .cmd_out_ch   (cmd_out_ch),
        .cmd_src_addr (cmd_src_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rdata    (mem_rdata),
        .weight_waddr (weight_waddr),
        .weight_wdata (weight_wdata),
        .weight_wen   (weight_wen),
        .busy         (busy),
        .done         (done)
    );

    initial forever #5 clk = ~clk;

    // Monitor and grant driver share one negedge process so cycle stamps agree.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (cmd_valid && cmd_ready) begin
            accept_cnt++;
            accept_cyc.push_back(cyc);
        end
        if (weight_wen) wr_q.push_back('{weight_waddr, weight_wdata, done, cyc});
        else if (weight_waddr !== 32'h0 || weight_wdata !== 32'h0) zero_viol++;
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (busy) busy_viol++;
        end
        if (weight_wen && !done && !busy) busy_viol++;
        if (mem_req && prev_req && !prev_gnt && mem_addr !== prev_addr) hold_viol++;
        case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       begin mem_gnt = toggle_ph; toggle_ph = ~toggle_ph; end
            default: mem_gnt = ($urandom_range(0, 9) < 6);
        endcase
        if (mem_req && mem_gnt) begin
            grant_cnt++;
            grant_cyc.push_back(cyc);
            grant_addr.push_back(mem_addr);
            pend  = 1'b1;
            paddr = mem_addr;
        end else begin
            pend = 1'b0;
        end
        prev_req  = mem_req;
        prev_gnt  = mem_gnt;
        prev_addr = mem_addr;
    end

    // Read data appears the cycle after a grant; otherwise the bus carries junk.
    initial forever begin
        @(posedge clk);
        #1;
        mem_rdata = pend ? sram[paddr[9:0]] : $urandom();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete();
        exp_q.delete();
        grant_cyc.delete();
        grant_addr.delete();
        accept_cyc.delete();
        done_cyc.delete();
        accept_cnt = 0;
        done_cnt   = 0;
        grant_cnt  = 0;
        hold_viol  = 0;
    endtask

    // Reference: a block is the list of (offset, in_ch) pairs, offset outer, each reading src+k.
    task automatic model_block(input bit is1x1, input logic [7:0] oc, input logic [15:0] src);
        int          n_words;
        logic [15:0] a;
        exp_t        e;
        n_words = is1x1 ? 16 : 144;
        for (int k = 0; k < n_words; k++) begin
            a       = src + 16'(k);
            e.waddr = (32'(is1x1) << 31) | (32'(oc) << 23) | (32'(k / 16) << 6) | 32'(k % 16);
            e.wdata = sram[a[9:0]];
            e.done  = (k == n_words - 1);
            exp_q.push_back(e);
        end
    endtask

    function automatic int count_mismatches();
        int bad = 0;
        if (wr_q.size() != exp_q.size()) bad++;
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            if (wr_q[i].waddr !== exp_q[i].waddr || wr_q[i].wdata !== exp_q[i].wdata ||
                wr_q[i].done !== exp_q[i].done) bad++;
        end
        return bad;
    endfunction

    task automatic issue_cmd(input bit is1x1, input logic [7:0] oc, input logic [15:0] src);
        int n0 = accept_cnt;
        int budget = 0;
        cmd_valid    = 1'b1;
        cmd_is1x1    = is1x1;
        cmd_out_ch   = oc;
        cmd_src_addr = src;
        while (accept_cnt == n0 && budget < 500) begin
            step();
            budget++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (accept_cnt == n0) begin
            errors++;
            $display("FAIL cmd_accept_timeout: got no acceptance after %0d cycles, expected one", budget);
        end
    endtask

    task automatic wait_done(input int target);
        int budget = 0;
        while (done_cnt < target && budget < 2000) begin
            step();
            budget++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, target);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready);
        end
        checks++;
        if ({mem_req, mem_addr, weight_waddr, weight_wdata, weight_wen, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b addr=%h waddr=%h wdata=%h wen=%b busy=%b done=%b expected all 0",
                     mem_req, mem_addr, weight_waddr, weight_wdata, weight_wen, busy, done);
        end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: got ready=%b busy=%b expected ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_1x1_continuous();
        gnt_mode = 0;
        clear_logs();
        model_block(1'b1, 8'h05, 16'h0100);
        issue_cmd(1'b1, 8'h05, 16'h0100);
        wait_done(1);
        step();
        checks++;
        if (count_mismatches() !== 0) begin
            errors++;
            $display("FAIL 1x1_writes: got %0d bad of %0d writes, expected 0 bad of 16", count_mismatches(), wr_q.size());
        end
        checks++;
        if (wr_q.size() != 16 || wr_q[0].waddr !== 32'h82800000 || wr_q[15].waddr !== 32'h8280000F) begin
            errors++;
            $display("FAIL 1x1_waddr_range: got %0d writes, expected 0x82800000..0x8280000F", wr_q.size());
        end
        checks++;
        if (accept_cyc.size() != 1 || done_cyc.size() != 1 || done_cyc[0] - accept_cyc[0] + 1 != 18) begin
            errors++;
            $display("FAIL 1x1_latency: got accepts=%0d dones=%0d, expected 18-cycle block", accept_cyc.size(), done_cyc.size());
        end
        checks++;
        if (grant_addr.size() != 16 || grant_addr[0] !== 16'h0100 || grant_addr[15] !== 16'h010F) begin
            errors++;
            $display("FAIL 1x1_mem_addr: got %0d grants, expected 16 over 0x0100..0x010F", grant_addr.size());
        end
    endtask

    task automatic test_3x3_continuous();
        gnt_mode = 0;
        clear_logs();
        model_block(1'b0, 8'h12, 16'h0000);
        issue_cmd(1'b0, 8'h12, 16'h0000);
        wait_done(1);
        step();
        checks++;
        if (count_mismatches() !== 0) begin
            errors++;
            $display("FAIL 3x3_writes: got %0d bad of %0d writes, expected 0 bad of 144", count_mismatches(), wr_q.size());
        end
        checks++;
        if (wr_q.size() != 144 || wr_q[17].waddr !== 32'h09000041 || wr_q[143].waddr !== 32'h0900020F) begin
            errors++;
            $display("FAIL 3x3_waddr_points: got %0d writes, expected [17]=09000041 [143]=0900020F", wr_q.size());
        end
    endtask

    task automatic test_gnt_toggle();
        logic [7:0]  oc;
        logic [15:0] src;
        int          bad_lat, bad_gap, bad_addr;
        gnt_mode = 1;
        clear_logs();
        oc  = 8'($urandom());
        src = 16'($urandom());
        model_block(1'b1, oc, src);
        issue_cmd(1'b1, oc, src);
        wait_done(1);
        step();
        checks++;
        if (count_mismatches() !== 0) begin
            errors++;
            $display("FAIL toggle_writes: got %0d bad of %0d writes, expected 0", count_mismatches(), wr_q.size());
        end
        bad_lat = 0;
        bad_gap = 0;
        bad_addr = 0;
        for (int i = 0; i < wr_q.size() && i < grant_cyc.size(); i++)
            if (wr_q[i].cyc != grant_cyc[i] + 1) bad_lat++;
        for (int i = 1; i < grant_cyc.size(); i++)
            if (grant_cyc[i] - grant_cyc[i-1] != 2) bad_gap++;
        for (int i = 0; i < grant_addr.size(); i++)
            if (grant_addr[i] !== src + 16'(i)) bad_addr++;
        checks++;
        if (bad_lat != 0 || grant_cyc.size() != 16) begin
            errors++;
            $display("FAIL toggle_wen_latency: got %0d late writes of %0d grants, expected 0 of 16", bad_lat, grant_cyc.size());
        end
        checks++;
        if (bad_gap != 0 || hold_viol != 0 || bad_addr != 0) begin
            errors++;
            $display("FAIL toggle_addr_hold: got gaps=%0d holds=%0d addrs=%0d, expected all 0", bad_gap, hold_viol, bad_addr);
        end
    endtask

    task automatic test_valid_held();
        logic [7:0]  oc;
        logic [15:0] src;
        int          budget;
        gnt_mode = 2;
        clear_logs();
        oc  = 8'($urandom());
        src = 16'($urandom());
        model_block(1'b1, oc, src);
        model_block(1'b1, oc, src);
        cmd_valid    = 1'b1;
        cmd_is1x1    = 1'b1;
        cmd_out_ch   = oc;
        cmd_src_addr = src;
        budget = 0;
        while (accept_cnt < 2 && budget < 500) begin
            step();
            budget++;
        end
        cmd_valid = 1'b0;
        wait_done(2);
        step();
        checks++;
        if (accept_cyc.size() != 2 || done_cyc.size() < 1 || accept_cyc[1] != done_cyc[0] + 1) begin
            errors++;
            $display("FAIL held_valid_reaccept: got %0d accepts, expected second one the cycle after done", accept_cyc.size());
        end
        checks++;
        if (count_mismatches() !== 0) begin
            errors++;
            $display("FAIL held_valid_writes: got %0d bad of %0d writes, expected 0 of 32", count_mismatches(), wr_q.size());
        end
    endtask

    task automatic test_reset_mid_block();
        logic [7:0]  oc;
        logic [15:0] src;
        int          budget, done0, wr0;
        bit          is1x1;
        gnt_mode = 0;
        clear_logs();
        issue_cmd(1'b0, 8'($urandom()), 16'($urandom()));
        budget = 0;
        while (grant_cnt < 50 && budget < 500) begin
            step();
            budget++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, mem_req, mem_addr, weight_waddr, weight_wdata, weight_wen, busy, done} !== '0 || grant_cnt != 50) begin
            errors++;
            $display("FAIL midreset_outputs: got grants=%0d req=%b addr=%h wen=%b wdata=%h busy=%b expected 50 grants, all 0",
                     grant_cnt, mem_req, mem_addr, weight_wen, weight_wdata, busy);
        end
        done0 = done_cnt;
        wr0   = wr_q.size();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (done_cnt != done0 || wr_q.size() != wr0 || done0 != 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_abandon: got done=%0d extra_writes=%0d busy=%b ready=%b expected none, idle",
                     done_cnt, wr_q.size() - wr0, busy, cmd_ready);
        end
        gnt_mode = 2;
        clear_logs();
        is1x1 = 1'($urandom());
        oc    = 8'($urandom());
        src   = 16'($urandom());
        model_block(is1x1, oc, src);
        issue_cmd(is1x1, oc, src);
        wait_done(1);
        step();
        checks++;
        if (count_mismatches() !== 0 || grant_addr.size() == 0 || grant_addr[0] !== src) begin
            errors++;
            $display("FAIL postreset_block: got %0d bad writes, expected clean block from word 0 at %h", count_mismatches(), src);
        end
    endtask

    task automatic test_back_to_back();
        int toggles, toggles_done;
        logic [7:0]  oc;
        logic [15:0] src;
        gnt_mode = 2;
        clear_logs();
        for (int b = 0; b < 4; b++) begin
            oc  = 8'($urandom());
            src = 16'($urandom());
            model_block(1'b1, oc, src);
            issue_cmd(1'b1, oc, src);
            wait_done(b + 1);
        end
        step();
        toggles = 0;
        toggles_done = 0;
        for (int i = 0; i < wr_q.size(); i++) begin
            if (wr_q[i].waddr[3:0] == 4'hF && wr_q[i].waddr[31]) begin
                toggles++;
                if (wr_q[i].done) toggles_done++;
            end
        end
        checks++;
        if (toggles != 4 || toggles_done != 4) begin
            errors++;
            $display("FAIL b2b_toggle_events: got %0d (%0d with done), expected 4 (4)", toggles, toggles_done);
        end
        checks++;
        if (count_mismatches() !== 0) begin
            errors++;
            $display("FAIL b2b_writes: got %0d bad of %0d writes, expected 0 of 64", count_mismatches(), wr_q.size());
        end
    endtask

    task automatic test_random_blocks();
        bit          is1x1;
        logic [7:0]  oc;
        logic [15:0] src;
        gnt_mode = 2;
        clear_logs();
        for (int b = 0; b < 5; b++) begin
            is1x1 = 1'($urandom());
            oc    = 8'($urandom());
            src   = 16'($urandom());
            model_block(is1x1, oc, src);
            issue_cmd(is1x1, oc, src);
            wait_done(b + 1);
        end
        step();
        checks++;
        if (count_mismatches() !== 0 || hold_viol != 0) begin
            errors++;
            $display("FAIL random_blocks: got %0d bad writes, %0d addr moves without grant, expected 0", count_mismatches(), hold_viol);
        end
    endtask

    task automatic test_idle_outputs();
        checks++;
        if (zero_viol != 0) begin
            errors++;
            $display("FAIL idle_write_bus: got %0d cycles with nonzero waddr/wdata while wen=0, expected 0", zero_viol);
        end
        checks++;
        if (busy_viol != 0) begin
            errors++;
            $display("FAIL busy_window: got %0d busy violations, expected 0", busy_viol);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = $urandom();
        test_reset();
        test_1x1_continuous();
        test_3x3_continuous();
        test_gnt_toggle();
        test_valid_held();
        test_reset_mid_block();
        test_back_to_back();
        test_random_blocks();
        test_idle_outputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_load_issuer.md
WEIGHT_LOAD_ISSUER -- requirements
Module: weight_load_issuer

Interface
REQ-001 SHALL have parameter MEM_AW, default 16, weight SRAM word-address width.
REQ-002 SHALL have parameter IN_CH, default 16, input channels per kernel block; fixed at 16.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, load command request.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid & cmd_ready.
REQ-007 SHALL have port cmd_is1x1, input, 1, kernel type: 1 = 1x1, 0 = 3x3.
REQ-008 SHALL have port cmd_out_ch, input, 8, output-channel index.
REQ-009 SHALL have port cmd_src_addr, input, MEM_AW, first SRAM word of the block.
REQ-010 SHALL have port mem_req, output, 1, SRAM read request.
REQ-011 SHALL have port mem_addr, output, MEM_AW, SRAM read address.
REQ-012 SHALL have port mem_gnt, input, 1, read granted this cycle.
REQ-013 SHALL have port mem_rdata, input, 32, read data, valid exactly one cycle after a granted request.
REQ-014 SHALL have port weight_waddr, output, 32, encoded weight write address.
REQ-015 SHALL have port weight_wdata, output, 32, weight word.
REQ-016 SHALL have port weight_wen, output, 1, write strobe.
REQ-017 SHALL have port busy, output, 1, high from command acceptance until done.
REQ-018 SHALL have port done, output, 1, single-cycle pulse on block completion.

Function
REQ-019 SHALL use FSM states IDLE, FETCH, LAST; cmd_ready = (state==IDLE).
REQ-020 SHALL, on acceptance, latch the command, clear counters and enter FETCH the next cycle.
REQ-021 SHALL, in FETCH, hold mem_req=1 with mem_addr = src_addr + word index; the index advances only on mem_gnt.
REQ-022 SHALL issue 16 words for 1x1 and 144 words for 3x3, ordered kernel offset outer (0..8), in_ch inner (0..15).
REQ-023 SHALL, on the grant of the final word, drop mem_req and move to LAST; LAST returns to IDLE after one cycle.
REQ-024 SHALL assert weight_wen exactly one cycle after each grant, with weight_wdata = mem_rdata on that cycle.
REQ-025 SHALL encode weight_waddr as: [31]=is1x1, [30:23]=out_ch, [9:6]=offset (0 for 1x1), [3:0]=in_ch of the granted word, all other bits 0.
REQ-026 SHALL register weight_waddr alongside the grant so the address and data are cycle-aligned.
REQ-027 SHALL pulse done in the LAST cycle, coincident with the final weight_wen; busy deasserts the same cycle.
REQ-028 SHALL drive weight_waddr, weight_wdata and weight_wen to 0 on cycles without a write.
REQ-029 SHALL tolerate mem_gnt gaps of any length; wen then carries the same gaps, with no write lost or duplicated.
REQ-030 SHALL ignore cmd_valid while busy; a command offered in the LAST cycle is not accepted until IDLE.
REQ-031 SHALL produce the final 1x1 write with waddr[3:0]=15, which is the downstream ping-pong toggle event.

Reset
REQ-032 SHALL, on rst_n low and independent of clk, enter IDLE and clear all counters and latched fields.
REQ-033 SHALL drive these values during reset: cmd_ready=0 while rst_n is low and 1 after release, plus mem_req=0, mem_addr=0, weight_waddr=0, weight_wdata=0, weight_wen=0, busy=0 and done=0.
REQ-034 SHALL, on reset mid-block, abandon the block, neither completing nor pulsing done, and drop any read data already in flight.

Structure
REQ-035 SHALL place the waddr field positions (bit 31, 30:23, 9:6, 3:0), word counts 16/144 and FSM state encodings in the shared accelerator package used by the weight-load path.
REQ-036 SHALL implement the waddr bit packing as one sub-module, weight_addr_pack, with inputs is1x1, out_ch, offset and in_ch.

Verification
REQ-037 SHALL cover a 1x1 load with out_ch=0x05, src=0x0100 and continuous gnt -> 16 wen, waddr 0x82800000..0x8280000F, done on the 16th wen, 18 cycles total.
REQ-038 SHALL cover a 3x3 load with out_ch=0x12, src=0x0000 -> 144 wen; write 17 has waddr 0x09000041 and the last has 0x0900020F.
REQ-039 SHALL cover gnt toggling 1-0-1-0 during a 1x1 load -> wen follows each grant by one cycle, mem_addr holds during gaps, and the wdata sequence equals SRAM contents.
REQ-040 SHALL cover cmd_valid held high through a block -> a second acceptance only in the cycle after done.
REQ-041 SHALL cover rst_n pulsed low after the 50th 3x3 grant -> outputs 0 immediately, no done, and a new command runs cleanly from word 0.
REQ-042 SHALL cover back-to-back 1x1 commands -> a waddr[3:0]=15 write with bit 31=1 occurs exactly once per block.
